rvx_module_019: RTL and testbench

// Slave endpoint on the serial service ring (svring) for register-access controllers.

---
 rtl/rvx_module_019.sv | 130 +++++++++++++
 tb/tb_rvx_module_019.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvx_module_019.sv
// Slave endpoint on the serial service ring: forwards foreign packets, collects requests
// addressed to NODE_ID into a parallel request and returns the result to MASTER_ID.
module rvx_module_019 #(
  parameter int NODE_ID    = 0,
  parameter int BW_NODE_ID = 8,
  parameter int BW_LINK    = 10,
  parameter int MASTER_ID  = 0,
  parameter int BW_REQ     = 40,
  parameter int BW_DATA    = 32
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic [BW_LINK-1:0] rx_link,
  output logic               rx_ready,
  output logic [BW_LINK-1:0] tx_link,
  input  logic               tx_ready,
  output logic               req_valid,
  output logic [BW_REQ-1:0]  req_data,
  input  logic               req_ack,
  input  logic [BW_DATA-1:0] rsp_data
);

  localparam int P    = BW_LINK - 2;
  localparam int NREQ = (BW_REQ + P - 1) / P;
  localparam int NRSP = (BW_DATA + P - 1) / P;
  localparam int RSW  = NRSP * P;
  localparam int CMAX = (NREQ > NRSP) ? NREQ : NRSP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(NREQ - 1);
  localparam logic [CW-1:0] RSP_LAST = CW'(NRSP);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FORWARD = 3'd1,
    S_COLLECT = 3'd2,
    S_REQ     = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [BW_LINK-1:0] tx_q;
  logic [BW_REQ-1:0]  req_q;
  logic               req_valid_q;
  logic [RSW-1:0]     rsp_q;
  logic [CW-1:0]      cnt_q;

  logic         rx_valid, rx_head, rx_own, rx_fire, slot_free;
  logic [P-1:0] rx_payload;
  logic         fwd_load, col_start, col_shift, col_last, req_take, rsp_emit, rsp_last;
  logic [BW_LINK-1:0] rsp_flit;

  assign rx_valid   = rx_link[BW_LINK-1];
  assign rx_head    = rx_link[BW_LINK-2];
  assign rx_payload = rx_link[P-1:0];
  assign rx_own     = (rx_payload[BW_NODE_ID-1:0] == BW_NODE_ID'(NODE_ID));
  assign slot_free  = !tx_q[BW_LINK-1] || tx_ready;

  // Handshake: a flit moves on a link only in a cycle where its valid bit and the
  // matching ready are both high; the sender holds the flit unchanged until then.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FORWARD, S_COLLECT: begin
        if (col_start)                  state_d = S_COLLECT;
        else if (fwd_load && rx_head)   state_d = S_FORWARD;
        else if (col_shift && col_last) state_d = S_REQ;
      end
      S_REQ:   if (req_ack) state_d = S_RESP;
      S_RESP:  if (rsp_emit && rsp_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_IDLE, S_FORWARD: rx_ready = slot_free;
      // Bodies are absorbed unconditionally; an aborting head may need the tx slot.
      S_COLLECT:         rx_ready = rx_head ? slot_free : 1'b1;
      default:           rx_ready = 1'b0;
    endcase
    rx_fire   = rx_valid && rx_ready;
    col_start = rx_fire && rx_head && rx_own;
    fwd_load  = rx_fire && ((rx_head && !rx_own) || (!rx_head && state_q == S_FORWARD));
    col_shift = rx_fire && !rx_head && state_q == S_COLLECT;
    col_last  = (cnt_q == REQ_LAST);
    req_take  = (state_q == S_REQ) && req_ack;
    rsp_emit  = (state_q == S_RESP) && slot_free;
    rsp_last  = (cnt_q == RSP_LAST);
    if (cnt_q == '0) rsp_flit = {1'b1, 1'b1, P'(MASTER_ID)};
    else             rsp_flit = {1'b1, 1'b0, rsp_q[RSW-1 -: P]};
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      tx_q        <= '0;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      rsp_q       <= '0;
      cnt_q       <= '0;
    end else begin
      if (fwd_load)      tx_q <= rx_link;
      else if (rsp_emit) tx_q <= rsp_flit;
      else if (tx_ready) tx_q <= '0;

      if (col_start || req_take) cnt_q <= '0;
      else if (col_shift || rsp_emit) cnt_q <= cnt_q + 1'b1;

      // MS chunk arrives first; zero padding of the first chunk falls off the top.
      if (col_shift) req_q <= BW_REQ'({req_q, rx_payload});

      if (col_shift && col_last) req_valid_q <= 1'b1;
      else if (req_take)         req_valid_q <= 1'b0;

      if (req_take) rsp_q <= RSW'(rsp_data);
      else if (rsp_emit && cnt_q != '0) rsp_q <= rsp_q << P;
    end
  end

  assign tx_link   = tx_q;
  assign req_valid = req_valid_q;
  assign req_data  = req_q;

endmodule

// File: tb/tb_rvx_module_019.sv
// Bench for rvx_module_019 with NODE_ID=3, MASTER_ID=0, 8-bit payload, 5 request / 4 response flits.
module tb_rvx_module_019;

  logic        clk;
  logic        rstnn;
  logic [9:0]  rx_link;
  logic        rx_ready;
  logic [9:0]  tx_link;
  logic        tx_ready;
  logic        req_valid;
  logic [39:0] req_data;
  logic        req_ack;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0]  exp_tx_q[$];
  logic [39:0] exp_req_q[$];
  logic        req_prev = 1'b0;

  rvx_module_019 #(
    .NODE_ID(3), .BW_NODE_ID(8), .BW_LINK(10), .MASTER_ID(0), .BW_REQ(40), .BW_DATA(32)
  ) dut (
    .clk(clk), .rstnn(rstnn), .rx_link(rx_link), .rx_ready(rx_ready),
    .tx_link(tx_link), .tx_ready(tx_ready), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .rsp_data(rsp_data)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitors / scoreboard
  always @(negedge clk) begin
    if (rstnn && tx_link[9] && tx_ready) begin
      if (exp_tx_q.size() == 0) begin
        n_checks++;
        $display("FAIL tx_unexpected: got %0h expected none", tx_link);
      end else begin
        chk("tx_flit", 64'(tx_link), 64'(exp_tx_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rstnn && req_valid && !req_prev) begin
      if (exp_req_q.size() == 0) begin
        n_checks++;
        $display("FAIL req_unexpected: got %0h expected none", req_data);
      end else begin
        chk("req_data", 64'(req_data), 64'(exp_req_q.pop_front()));
      end
    end
    req_prev = req_valid;
  end

  // drivers
  task automatic send(input bit hd, input logic [7:0] pl);
    bit ok;
    ok = 1'b0;
    rx_link = {1'b1, hd, pl};
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL rx_accept_timeout: got no rx_ready expected accept of %0h", rx_link);
    end
    @(posedge clk);
    #1;
    rx_link = '0;
  endtask

  task automatic send_req(input logic [39:0] r);
    logic [39:0] v;
    v = r;
    send(1'b1, 8'h03);
    for (int i = 4; i >= 0; i--) send(1'b0, v[i*8 +: 8]);
  endtask

  task automatic respond(input logic [31:0] d, input int delay);
    bit ok;
    logic [31:0] v;
    v = d;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL req_valid_timeout: got 0 expected 1");
    end
    repeat (delay) @(posedge clk);
    #1;
    chk("req_valid_held", 64'(req_valid), 64'd1);
    exp_tx_q.push_back(10'h300);
    for (int i = 3; i >= 0; i--) exp_tx_q.push_back({2'b10, v[i*8 +: 8]});
    req_ack  = 1'b1;
    rsp_data = v;
    @(posedge clk);
    #1;
    req_ack = 1'b0;
    chk("req_valid_cleared", 64'(req_valid), 64'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_tx_q.size() == 0) break;
    end
    @(posedge clk);
    #1;
    chk("tx_drain", 64'(exp_tx_q.size()), 64'd0);
  endtask

  initial begin
    rstnn    = 1'b0;
    rx_link  = '0;
    tx_ready = 1'b1;
    req_ack  = 1'b0;
    rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_link", 64'(tx_link), 64'd0);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_req_data", 64'(req_data), 64'd0);
    rstnn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // foreign packet passes through with one cycle latency
    exp_tx_q.push_back(10'h305);
    exp_tx_q.push_back(10'h2AA);
    exp_tx_q.push_back(10'h2BB);
    send(1'b1, 8'h05);
    chk("fwd_latency", 64'(tx_link), 64'h305);
    send(1'b0, 8'hAA);
    send(1'b0, 8'hBB);
    drain();
    chk("fwd_no_req", 64'(req_valid), 64'd0);

    // own request, then response DEADBEEF after 4 cycles
    exp_req_q.push_back(40'h123456789A);
    send_req(40'h123456789A);
    chk("collect_no_tx", 64'(tx_link[9]), 64'd0);
    respond(32'hDEADBEEF, 4);
    drain();

    // backpressure mid-forward
    exp_tx_q.push_back(10'h307);
    exp_tx_q.push_back(10'h211);
    exp_tx_q.push_back(10'h222);
    exp_tx_q.push_back(10'h233);
    send(1'b1, 8'h07);
    send(1'b0, 8'h11);
    rx_link  = {2'b10, 8'h22};
    tx_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rx_ready", 64'(rx_ready), 64'd0);
      chk("bp_tx_hold", 64'(tx_link), 64'h211);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    send(1'b0, 8'h22);
    send(1'b0, 8'h33);
    drain();

    // reset in the middle of a collection
    send(1'b1, 8'h03);
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    #2;
    rstnn = 1'b0;
    #1;
    chk("midrst_tx_link", 64'(tx_link), 64'd0);
    chk("midrst_req_valid", 64'(req_valid), 64'd0);
    chk("midrst_req_data", 64'(req_data), 64'd0);
    @(posedge clk);
    #1;
    rstnn = 1'b1;
    exp_req_q.push_back(40'hA1A2A3A4A5);
    send_req(40'hA1A2A3A4A5);
    respond(32'h01234567, 0);
    drain();

    // back-to-back foreign then own packet
    exp_tx_q.push_back(10'h309);
    exp_tx_q.push_back(10'h2C1);
    exp_tx_q.push_back(10'h2C2);
    exp_req_q.push_back(40'hB1B2B3B4B5);
    send(1'b1, 8'h09);
    send(1'b0, 8'hC1);
    send(1'b0, 8'hC2);
    send_req(40'hB1B2B3B4B5);
    respond(32'hCAFEF00D, 2);
    drain();

    // final report
    chk("req_q_empty", 64'(exp_req_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
